blinker_input_cond: RTL and testbench

Input conditioner that sits directly upstream of the LED blinker. It synchronises and debounces four raw board switches and an active-low pause pushbutton. It presents a stable 4-bit `delay` value and a single-cycle `pause` pulse that the blinker consumes. All outputs are registered and glitch-free.

---
 rtl/blinker_input_cond.sv | 140 ++++++++++++++
 tb/tb_blinker_input_cond.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/blinker_input_cond.sv
// Input conditioner for the LED blinker: synchronises and debounces four switches and an
// active-low pause button. Optional auto-repeat of pause is enabled by BLINKER_IN_AUTOREPEAT_EN.
module blinker_input_cond #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn_pause_n,
  output logic [3:0] delay,
  output logic       pause,
  output logic       delay_changed
);

  localparam int NIN = 5;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NIN-1:0] IDLE_VAL = 5'b1_0000;  // button released, switches low
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 1");
  end

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync_chain [SYNC_STAGES];
  logic [NIN-1:0] synced;
  logic [NIN-1:0] stable;
  logic [CW-1:0]  cnt [NIN];
  logic [NIN-1:0] accept;
  logic           press;
  logic           repeat_fire;
  logic           pause_r;
  logic           delay_changed_r;

  assign raw    = {btn_pause_n, sw};
  assign synced = sync_chain[SYNC_STAGES-1];

  // Synchroniser chains, one per input bit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_chain[s] <= IDLE_VAL;
      end
    end else begin
      sync_chain[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_chain[s] <= sync_chain[s-1];
      end
    end
  end

  // A bit is accepted once it has disagreed long enough for its counter to sit at the limit
  always_comb begin
    accept = '0;
    for (int i = 0; i < NIN; i++) begin
      if ((synced[i] != stable[i]) && (cnt[i] == CNT_MAX)) begin
        accept[i] = 1'b1;
      end else begin
        accept[i] = 1'b0;
      end
    end
  end

  // Per-input debounce counters and stable registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= IDLE_VAL;
      for (int i = 0; i < NIN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (synced[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]    <= '0;
          stable[i] <= synced[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is the stable button going from released to pressed
  assign press = accept[4] & ~synced[4];

`ifdef BLINKER_IN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt;

  // Re-pulse while held; a release about to be accepted suppresses the repeat
  always_comb begin
    repeat_fire = 1'b0;
    if (!stable[4] && !accept[4] && (rep_cnt == REP_LAST)) begin
      repeat_fire = 1'b1;
    end else begin
      repeat_fire = 1'b0;
    end
  end

  // Cycles since the last pause pulse while the button is held
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (stable[4] || accept[4] || repeat_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  // Registered single-cycle output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_r         <= 1'b0;
      delay_changed_r <= 1'b0;
    end else begin
      pause_r         <= press | repeat_fire;
      delay_changed_r <= |accept[3:0];
    end
  end

  assign delay         = stable[3:0];
  assign pause         = pause_r;
  assign delay_changed = delay_changed_r;

endmodule

// File: tb/tb_blinker_input_cond.sv
// Self-checking bench for blinker_input_cond: directed literal scenarios plus a random run
// compared every cycle against a sliding-window behavioural model.
module tb_blinker_input_cond;
  localparam int D   = 8;
  localparam int S   = 2;
  localparam int R   = 16;
  localparam logic [4:0] DEF = 5'b1_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = 4'b1111;
  logic       btn_pause_n = 1'b0;
  logic [3:0] delay;
  logic       pause;
  logic       delay_changed;

  int errors = 0;
  int checks = 0;

  blinker_input_cond #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_pause_n(btn_pause_n),
    .delay(delay), .pause(pause), .delay_changed(delay_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: raw samples delayed by S edges; a value is accepted when the last
  // D+1 delayed samples all differ from the current stable value.
  logic [4:0] in_hist [S];
  logic [4:0] win [D+1];
  logic [4:0] m_stable;
  logic       m_pause, m_changed;
  int         m_since;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    logic [4:0] acc;
    logic press, rep;
    if (reset) begin
      for (int k = 0; k < S; k++) in_hist[k] = DEF;
      for (int k = 0; k <= D; k++) win[k] = DEF;
      m_stable = DEF; m_pause = 1'b0; m_changed = 1'b0; m_since = 0; m_valid = 1'b1;
    end else begin
      for (int k = D; k > 0; k--) win[k] = win[k-1];
      win[0] = in_hist[S-1];
      acc = 5'b11111;
      for (int k = 0; k <= D; k++) acc = acc & (win[k] ^ m_stable);
      m_changed = |acc[3:0];
      press = acc[4] & m_stable[4];
      rep = 1'b0;
`ifdef BLINKER_IN_AUTOREPEAT_EN
      if (!m_stable[4] && !acc[4]) begin
        m_since++;
        if (m_since == R) begin
          rep = 1'b1;
          m_since = 0;
        end
      end
      if (press) m_since = 0;
`endif
      m_pause = press | rep;
      m_stable = m_stable ^ acc;
      for (int k = S - 1; k > 0; k--) in_hist[k] = in_hist[k-1];
      in_hist[0] = {btn_pause_n, sw};
    end
    #1;
    if (m_valid) begin
      chk("model_delay", delay, m_stable[3:0]);
      chk("model_pause", {3'b000, pause}, {3'b000, m_pause});
      chk("model_delay_changed", {3'b000, delay_changed}, {3'b000, m_changed});
    end
  end

  function automatic logic exp_btn_held(input int c);
`ifdef BLINKER_IN_AUTOREPEAT_EN
    return (c == 10) || (c == 26) || (c == 42);
`else
    return (c == 10);
`endif
  endfunction

  initial begin
    int hold;
    // Reset with all inputs active
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset_delay", delay, 4'b0000);
      chk("reset_pause", {3'b000, pause}, 4'b0000);
      chk("reset_changed", {3'b000, delay_changed}, 4'b0000);
    end
    reset = 1'b0; sw = 4'b0000; btn_pause_n = 1'b1;
    repeat (20) step();

    // Switch change latency
    sw = 4'b0101;
    for (int c = 0; c <= 11; c++) begin
      step();
      if (c <= 9) chk("sw_latency_pre", delay, 4'b0000);
      if (c == 10) begin
        chk("sw_latency_delay", delay, 4'b0101);
        chk("sw_latency_changed", {3'b000, delay_changed}, 4'b0001);
      end
      if (c == 11) chk("sw_changed_width", {3'b000, delay_changed}, 4'b0000);
    end
    sw = 4'b0000;
    repeat (20) step();

    // Short glitch is discarded
    sw = 4'b0001;
    for (int c = 0; c < 25; c++) begin
      step();
      if (c == 4) sw = 4'b0000;
      chk("glitch_delay", delay, 4'b0000);
      chk("glitch_changed", {3'b000, delay_changed}, 4'b0000);
    end

    // Button press and release
    btn_pause_n = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (c == 39) btn_pause_n = 1'b1;
      chk("btn_press", {3'b000, pause}, {3'b000, exp_btn_held(c)});
    end
    repeat (10) step();

    // Reset while the button is held restarts debounce
    btn_pause_n = 1'b0;
    for (int c = 0; c < 31; c++) begin
      if (c == 6) reset = 1'b1;
      step();
      reset = 1'b0;
      chk("btn_reset_mid", {3'b000, pause}, {3'b000, (c == 17)});
    end
    btn_pause_n = 1'b1;
    repeat (20) step();

`ifdef BLINKER_IN_AUTOREPEAT_EN
    // Auto-repeat while held
    btn_pause_n = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      chk("autorepeat", {3'b000, pause},
          {3'b000, (c == 10) || (c == 26) || (c == 42) || (c == 58)});
    end
    btn_pause_n = 1'b1;
    repeat (20) step();
`endif

    // Random phase, checked by the model process
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
        else sw[$urandom_range(0, 3)] = ~sw[$urandom_range(0, 3)];
        if ($urandom_range(0, 2) == 0) btn_pause_n = ~btn_pause_n;
        hold = $urandom_range(1, 14);
      end
      hold--;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
